// File: rtl/fp16_mul_normround.sv
// fp16_mul_normround
// Back end of an FP16 multiplier. It takes the sign, the two raw biased
// exponents and the 22-bit significand product from the multiplier array.
// It then normalizes, rounds to nearest-even, handles specials and
// out-of-range exponents, and packs the IEEE FP16 result.
//
// Pipeline: S1 = classify/normalize/exponent, S2 = round/renormalize/pack.
// Valid/ready on both sides; 2-cycle latency, 1 result per cycle.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready          upstream handshake
//   in_sign                    sign_a ^ sign_b
//   in_exp_a, in_exp_b [4:0]   raw biased exponents
//   in_product [21:0]          11x11 significand product (implicit 1s included)
//   out_valid/out_ready        downstream handshake
//   out_result [15:0]          FP16 product
//   out_overflow/underflow/inexact  per-result exception flags
//
// Optional feature (macro FP16_MUL_STICKY_FLAGS_EN):
//   flag_clear (in)            zeroes the accumulated flags (wins over set)
//   sticky_flags [2:0] (out)   {overflow, underflow, inexact} OR-accumulated
//                              on every output handshake
module fp16_mul_normround (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [4:0]  in_exp_a,
  input  logic [4:0]  in_exp_b,
  input  logic [21:0] in_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
`ifdef FP16_MUL_STICKY_FLAGS_EN
  ,
  input  logic        flag_clear,
  output logic [2:0]  sticky_flags
`endif
);

  typedef enum logic [1:0] {
    KIND_NORM = 2'd0,
    KIND_ZERO = 2'd1,
    KIND_INF  = 2'd2,
    KIND_NAN  = 2'd3
  } kind_t;

  // S1 pipeline register
  logic              s1_valid_r;
  logic              s1_sign_r;
  kind_t             s1_kind_r;
  logic [9:0]        s1_mant_r;
  logic              s1_guard_r;
  logic              s1_sticky_r;
  logic signed [6:0] s1_exp_r;

  // S2 (output) register
  logic              s2_valid_r;
  logic [15:0]       result_r;
  logic              overflow_r;
  logic              underflow_r;
  logic              inexact_r;

  logic              s1_adv_s;
  logic              accept_s;

  assign s1_adv_s  = !s2_valid_r || out_ready;
  assign in_ready  = !s1_valid_r || s1_adv_s;
  assign accept_s  = in_valid && in_ready;

  assign out_valid     = s2_valid_r;
  assign out_result    = result_r;
  assign out_overflow  = overflow_r;
  assign out_underflow = underflow_r;
  assign out_inexact   = inexact_r;

  // S1 combinational: classification, normalization shift, unrounded exponent
  kind_t             kind_s;
  logic [9:0]        mant_s;
  logic              guard_s;
  logic              sticky_s;
  logic [6:0]        exp_sum_s;
  logic signed [6:0] exp_s;

  // Classify the operands and select the normalization window of the product
  always_comb begin
    kind_s    = KIND_NORM;
    mant_s    = 10'd0;
    guard_s   = 1'b0;
    sticky_s  = 1'b0;
    exp_sum_s = {2'b00, in_exp_a} + {2'b00, in_exp_b};
    exp_s     = 7'sd0;
    // Infinity/NaN operands take priority over zero/subnormal operands.
    if ((in_exp_a == 5'd31) || (in_exp_b == 5'd31)) begin
      if ((in_exp_a == 5'd0) || (in_exp_b == 5'd0)) begin
        kind_s = KIND_NAN;
      end else begin
        kind_s = KIND_INF;
      end
    end else if ((in_exp_a == 5'd0) || (in_exp_b == 5'd0)) begin
      kind_s = KIND_ZERO;
    end else begin
      kind_s = KIND_NORM;
    end
    // A product in [2,4) carries one more integer bit, hence bias 14 vs 15.
    if (in_product[21]) begin
      mant_s   = in_product[20:11];
      guard_s  = in_product[10];
      sticky_s = |in_product[9:0];
      exp_s    = $signed(exp_sum_s - 7'd14);
    end else begin
      mant_s   = in_product[19:10];
      guard_s  = in_product[9];
      sticky_s = |in_product[8:0];
      exp_s    = $signed(exp_sum_s - 7'd15);
    end
  end

  // S1 register: loads on accept, empties when its content moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_kind_r   <= KIND_ZERO;
      s1_mant_r   <= 10'd0;
      s1_guard_r  <= 1'b0;
      s1_sticky_r <= 1'b0;
      s1_exp_r    <= 7'sd0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (accept_s) begin
        s1_sign_r   <= in_sign;
        s1_kind_r   <= kind_s;
        s1_mant_r   <= mant_s;
        s1_guard_r  <= guard_s;
        s1_sticky_r <= sticky_s;
        s1_exp_r    <= exp_s;
      end
    end
  end

  // S2 combinational: round, renormalize, range-check and pack
  logic              inc_s;
  logic [10:0]       mant_sum_s;
  logic signed [6:0] exp_rnd_s;
  logic [15:0]       res_s;
  logic              ovf_s;
  logic              unf_s;
  logic              inx_s;

  // Round to nearest even; a mantissa carry leaves the field at zero
  always_comb begin
    inc_s      = s1_guard_r && (s1_sticky_r || s1_mant_r[0]);
    mant_sum_s = {1'b0, s1_mant_r} + {10'd0, inc_s};
    exp_rnd_s  = s1_exp_r + $signed({6'd0, mant_sum_s[10]});
    res_s      = 16'h0000;
    ovf_s      = 1'b0;
    unf_s      = 1'b0;
    inx_s      = 1'b0;
    case (s1_kind_r)
      KIND_NORM: begin
        if (exp_rnd_s >= 7'sd31) begin
          res_s = {s1_sign_r, 15'h7C00};
          ovf_s = 1'b1;
          inx_s = 1'b1;
        end else if (exp_rnd_s <= 7'sd0) begin
          res_s = {s1_sign_r, 15'h0000};
          unf_s = 1'b1;
          inx_s = 1'b1;
        end else begin
          res_s = {s1_sign_r, exp_rnd_s[4:0], mant_sum_s[9:0]};
          inx_s = s1_guard_r || s1_sticky_r;
        end
      end
      KIND_ZERO: res_s = {s1_sign_r, 15'h0000};
      KIND_INF:  res_s = {s1_sign_r, 15'h7C00};
      KIND_NAN:  res_s = 16'h7E00;
      default:   res_s = 16'h0000;
    endcase
  end

  // S2 register: holds its result until the downstream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r  <= 1'b0;
      result_r    <= 16'h0000;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      inexact_r   <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r    <= res_s;
        overflow_r  <= ovf_s;
        underflow_r <= unf_s;
        inexact_r   <= inx_s;
      end
    end
  end

`ifdef FP16_MUL_STICKY_FLAGS_EN
  logic [2:0] sticky_r;

  assign sticky_flags = sticky_r;

  // Accumulate flags of delivered results; clear has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_r <= 3'b000;
    end else if (flag_clear) begin
      sticky_r <= 3'b000;
    end else if (s2_valid_r && out_ready) begin
      sticky_r <= sticky_r | {overflow_r, underflow_r, inexact_r};
    end
  end
`endif

endmodule

// File: tb/tb_fp16_mul_normround.sv
module tb_fp16_mul_normround;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp_a;
  logic [4:0]  in_exp_b;
  logic [21:0] in_product;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;
`ifdef FP16_MUL_STICKY_FLAGS_EN
  logic        flag_clear;
  logic [2:0]  sticky_flags;
`endif

  // {result[15:0], overflow, underflow, inexact}
  logic [18:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;

  always #5 clk = ~clk;

  fp16_mul_normround dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp_a      (in_exp_a),
    .in_exp_b      (in_exp_b),
    .in_product    (in_product),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact)
`ifdef FP16_MUL_STICKY_FLAGS_EN
    ,
    .flag_clear    (flag_clear),
    .sticky_flags  (sticky_flags)
`endif
  );

  // Reference: treat the product as an integer significand with a known
  // binary point, round with remainder arithmetic, then range-check.
  function automatic logic [18:0] model(input logic s, input int ea, input int eb, input int p);
    int fb, m, rem, half, e;
    logic inx;
    logic [18:0] r;
    if (ea == 31 || eb == 31) begin
      if (ea == 0 || eb == 0) return {16'h7E00, 3'b000};
      return {s, 15'h7C00, 3'b000};
    end
    if (ea == 0 || eb == 0) return {s, 15'h0000, 3'b000};
    fb   = (p >= 2097152) ? 11 : 10;
    m    = p >> fb;
    rem  = p & ((1 << fb) - 1);
    half = 1 << (fb - 1);
    e    = ea + eb - 15 + (fb - 10);
    inx  = (rem != 0);
    if (rem > half || (rem == half && (m % 2) == 1)) m = m + 1;
    if (m == 2048) begin
      m = 1024;
      e = e + 1;
    end
    if (e >= 31) return {s, 15'h7C00, 3'b101};
    if (e <= 0)  return {s, 15'h0000, 3'b011};
    r = {s, e[4:0], m[9:0], 2'b00, inx};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got=%h required=%h at %0t", name, got, req, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got=no_event required=event at %0t", name, $time);
  endtask

  // Drive point is posedge+6; checks of combinational ready at +7
  task automatic step();
    @(posedge clk);
    #6;
  endtask

  task automatic drive_ready();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic s, input logic [4:0] ea, input logic [4:0] eb, input logic [21:0] p);
    bit done = 1'b0;
    in_valid   = 1'b1;
    in_sign    = s;
    in_exp_a   = ea;
    in_exp_b   = eb;
    in_product = p;
    for (int k = 0; k < 200 && !done; k++) begin
      drive_ready();
      #1;
      if (in_ready) begin
        exp_q.push_back(model(s, int'(ea), int'(eb), int'(p)));
        done = 1'b1;
      end
      step();
    end
    if (!done) fail_timeout("accept");
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      drive_ready();
      step();
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) step();
    if (exp_q.size() > 0) fail_timeout("drain");
    step();
  endtask

  // Monitor: compare the presented output against the queue head each
  // cycle it is valid; pop on handshake (so a held output is rechecked).
  initial begin
    forever begin
      @(posedge clk);
      #9;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got=%h required=none at %0t", out_result, $time);
        end else begin
          chk("result", {13'd0, out_result, out_overflow, out_underflow, out_inexact},
              {13'd0, exp_q[0]});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sign    = 1'b0;
    in_exp_a   = 5'd0;
    in_exp_b   = 5'd0;
    in_product = 22'd0;
    out_ready  = 1'b1;
`ifdef FP16_MUL_STICKY_FLAGS_EN
    flag_clear = 1'b0;
`endif
    step();
    step();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {16'd0, out_result}, 32'd0);
    chk("rst_flags", {29'd0, out_overflow, out_underflow, out_inexact}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();

    // Directed vectors
    send(1'b0, 5'd15, 5'd15, 22'h100000);
    send(1'b0, 5'd15, 5'd15, 22'h240000);
    send(1'b0, 5'd15, 5'd15, 22'h100200);
    send(1'b0, 5'd15, 5'd15, 22'h100600);
    send(1'b0, 5'd30, 5'd30, 22'h100000);
    send(1'b0, 5'd1,  5'd1,  22'h100000);
    send(1'b0, 5'd31, 5'd0,  22'h100000);
    send(1'b1, 5'd31, 5'd15, 22'h100000);
    send(1'b1, 5'd0,  5'd20, 22'h100000);
    send(1'b1, 5'd15, 5'd15, 22'h3FFFFF);
    drain();

    // Backpressure: two accepted, then in_ready must stay low
    out_ready = 1'b0;
    send(1'b0, 5'd16, 5'd14, 22'h180000);
    send(1'b1, 5'd17, 5'd15, 22'h2A0001);
    in_valid   = 1'b1;
    in_sign    = 1'b0;
    in_exp_a   = 5'd10;
    in_exp_b   = 5'd12;
    in_product = 22'h1FFC00;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("backpressure_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    send(1'b0, 5'd10, 5'd12, 22'h1FFC00);
    send(1'b1, 5'd20, 5'd20, 22'h300000);
    drain();

    // Randomized traffic with random downstream stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int a, b;
      a = $urandom_range(1024, 2047);
      b = $urandom_range(1024, 2047);
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           22'(a * b));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Reset with two bundles in flight: nothing stale may come out
    out_ready = 1'b0;
    send(1'b0, 5'd15, 5'd15, 22'h100000);
    send(1'b1, 5'd16, 5'd16, 22'h100000);
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    idle(6);
    send(1'b0, 5'd15, 5'd15, 22'h240000);
    drain();

`ifdef FP16_MUL_STICKY_FLAGS_EN
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    #1;
    chk("sticky_cleared", {29'd0, sticky_flags}, 32'd0);
    step();
    send(1'b0, 5'd30, 5'd30, 22'h100000);
    drain();
    #1;
    chk("sticky_overflow", {29'd0, sticky_flags}, 32'd5);
    step();
    flag_clear = 1'b1;
    step();
    flag_clear = 1'b0;
    #1;
    chk("sticky_clear_again", {29'd0, sticky_flags}, 32'd0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
